// File: rtl/knight_anim_ctrl.sv
// rtl/knight_anim_ctrl.sv - knight sprite walk-animation FSM and sprite ROM addressing
//
// Purpose:
//   Chooses which knight image ROM to display (idle or one of three walk
//   frames) and produces the per-pixel ROM address and sprite hit flag.
//   Animation state, position and facing change only at frame_tick, so one
//   displayed frame always uses one consistent set of sprite parameters.
//
// Ports:
//   vga_clk      in   pixel clock, sole clock
//   reset_n      in   synchronous active-low reset
//   frame_tick   in   one-cycle pulse at the start of vertical blank
//   walk_req     in   level, knight is moving horizontally
//   face_left    in   level, knight faces left
//   knight_x/y   in   [9:0] sprite top-left screen position
//   DrawX/DrawY  in   [9:0] current pixel coordinates
//   blank        in   high during the active display region
//   rom_sel      out  [1:0] 0 idle, 1 walk1, 2 walk2, 3 walk3
//   rom_address  out  [11:0] address into the selected sprite ROM
//   in_sprite    out  current pixel is inside the sprite box (registered)
//   anim_state   out  [1:0] 0 IDLE, 1 WALK, 2 STOP
//
// Configuration:
//   KNIGHT_MIRROR_EN  when defined, the sprite column is mirrored while the
//                     latched facing is left; otherwise face_left is ignored.

module knight_anim_ctrl #(
  parameter int SPR_W      = 50,
  parameter int SPR_H      = 64,
  parameter int FRAME_HOLD = 6
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        walk_req,
  input  logic        face_left,
  input  logic [9:0]  knight_x,
  input  logic [9:0]  knight_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [1:0]  rom_sel,
  output logic [11:0] rom_address,
  output logic        in_sprite,
  output logic [1:0]  anim_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(FRAME_HOLD - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  sel_q;
  logic [1:0]  sel_next;
  logic [3:0]  hold_cnt;
  logic [3:0]  hold_next;

  logic [9:0]  lat_x;
  logic [9:0]  lat_y;
  logic        lat_face;

  logic [10:0] lx;
  logic [10:0] ly;
  logic        hit;
  logic [11:0] col;
  logic [11:0] addr_next;

  // State register, animation frame select and hold counter
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sel_q    <= 2'd0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      sel_q    <= sel_next;
      hold_cnt <= hold_next;
    end
  end

  // Next-state logic; everything holds unless this is a frame_tick cycle
  always_comb begin
    state_next = state;
    sel_next   = sel_q;
    hold_next  = hold_cnt;
    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (walk_req) begin
            state_next = ST_WALK;
            sel_next   = 2'd1;
            hold_next  = 4'd0;
          end else begin
            sel_next   = 2'd0;
          end
        end
        ST_WALK: begin
          if (!walk_req) begin
            // Keep showing the current walk image for the stop frame
            state_next = ST_STOP;
          end else if (hold_cnt == HOLD_LAST) begin
            // The tick after the counter has sat at FRAME_HOLD-1 advances the
            // image, so every walk image is shown for FRAME_HOLD ticks.
            hold_next = 4'd0;
            sel_next  = (sel_q == 2'd3) ? 2'd1 : sel_q + 2'd1;
          end else begin
            hold_next = hold_cnt + 4'd1;
          end
        end
        ST_STOP: begin
          hold_next = 4'd0;
          if (walk_req) begin
            state_next = ST_WALK;
            sel_next   = 2'd1;
          end else begin
            state_next = ST_IDLE;
            sel_next   = 2'd0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          sel_next   = 2'd0;
          hold_next  = 4'd0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    anim_state = state;
    rom_sel    = sel_q;
  end

  // Position and facing snapshot, taken once per frame
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      lat_x    <= 10'd0;
      lat_y    <= 10'd0;
      lat_face <= 1'b0;
    end else if (frame_tick) begin
      lat_x    <= knight_x;
      lat_y    <= knight_y;
      lat_face <= face_left;
    end
  end

  // Offsets are taken at 11 bits so a pixel left of / above the sprite comes
  // out negative (bit 10 set) instead of wrapping around to a valid column.
  always_comb begin
    lx  = {1'b0, DrawX} - {1'b0, lat_x};
    ly  = {1'b0, DrawY} - {1'b0, lat_y};
    hit = !lx[10] && (lx[9:0] < 10'(SPR_W)) &&
          !ly[10] && (ly[9:0] < 10'(SPR_H));
  end

`ifdef KNIGHT_MIRROR_EN
  always_comb begin
    if (lat_face) col = 12'(SPR_W - 1) - {2'b0, lx[9:0]};
    else          col = {2'b0, lx[9:0]};
  end
`else
  logic unused_face;
  assign unused_face = lat_face;
  always_comb begin
    col = {2'b0, lx[9:0]};
  end
`endif

  always_comb begin
    addr_next = {2'b0, ly[9:0]} * 12'(SPR_W) + col;
  end

  // One-cycle pixel pipeline; misses and blanked pixels read address 0
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      in_sprite   <= 1'b0;
      rom_address <= 12'd0;
    end else begin
      in_sprite   <= blank && hit;
      rom_address <= (blank && hit) ? addr_next : 12'd0;
    end
  end

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// tb/tb_knight_anim_ctrl.sv - directed self-checking bench for knight_anim_ctrl

module tb_knight_anim_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        walk_req;
  logic        face_left;
  logic [9:0]  knight_x;
  logic [9:0]  knight_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [1:0]  rom_sel;
  logic [11:0] rom_address;
  logic        in_sprite;
  logic [1:0]  anim_state;

  int pass_cnt = 0;
  int total    = 0;

  knight_anim_ctrl #(.SPR_W(50), .SPR_H(64), .FRAME_HOLD(6)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .walk_req    (walk_req),
    .face_left   (face_left),
    .knight_x    (knight_x),
    .knight_y    (knight_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .rom_sel     (rom_sel),
    .rom_address (rom_address),
    .in_sprite   (in_sprite),
    .anim_state  (anim_state)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++; if (anim_state !== 2'd0) $display("FAIL reset_anim_state got %0d want 0", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd0) $display("FAIL reset_rom_sel got %0d want 0", rom_sel); else pass_cnt++;
    total++; if (in_sprite !== 1'b0) $display("FAIL reset_in_sprite got %0b want 0", in_sprite); else pass_cnt++;
    total++; if (rom_address !== 12'd0) $display("FAIL reset_rom_address got %0d want 0", rom_address); else pass_cnt++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_idle();
    walk_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (anim_state !== 2'd0) $display("FAIL idle_state tick %0d got %0d want 0", k, anim_state); else pass_cnt++;
      total++; if (rom_sel !== 2'd0) $display("FAIL idle_rom_sel tick %0d got %0d want 0", k, rom_sel); else pass_cnt++;
    end
  endtask

  task automatic test_walk_cycle();
    logic [1:0] exp_sel;
    walk_req = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k <= 6)       exp_sel = 2'd1;
      else if (k <= 12) exp_sel = 2'd2;
      else if (k <= 18) exp_sel = 2'd3;
      else              exp_sel = 2'd1;
      total++; if (rom_sel !== exp_sel) $display("FAIL walk_rom_sel tick %0d got %0d want %0d", k, rom_sel, exp_sel); else pass_cnt++;
      total++; if (anim_state !== 2'd1) $display("FAIL walk_state tick %0d got %0d want 1", k, anim_state); else pass_cnt++;
      if (k == 12) begin
        // no tick: nothing may change between frames
        step(); step(); step();
        total++; if (rom_sel !== 2'd2) $display("FAIL walk_hold_between_ticks got %0d want 2", rom_sel); else pass_cnt++;
      end
    end
  endtask

  task automatic test_stop();
    // after tick 19: rom_sel 1, counter 0; ticks 20..24 count to 5, tick 25 advances
    for (int k = 20; k <= 26; k++) tick();
    total++; if (rom_sel !== 2'd2) $display("FAIL stop_pre_sel got %0d want 2", rom_sel); else pass_cnt++;
    walk_req = 1'b0;
    step();
    total++; if (anim_state !== 2'd1) $display("FAIL stop_no_tick_state got %0d want 1", anim_state); else pass_cnt++;
    tick();
    total++; if (anim_state !== 2'd2) $display("FAIL stop_state got %0d want 2", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd2) $display("FAIL stop_sel_held got %0d want 2", rom_sel); else pass_cnt++;
    walk_req = 1'b1;
    tick();
    total++; if (anim_state !== 2'd1) $display("FAIL stop_rewalk_state got %0d want 1", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd1) $display("FAIL stop_rewalk_sel got %0d want 1", rom_sel); else pass_cnt++;
    walk_req = 1'b0;
    tick();
    total++; if (anim_state !== 2'd2) $display("FAIL stop2_state got %0d want 2", anim_state); else pass_cnt++;
    tick();
    total++; if (anim_state !== 2'd0) $display("FAIL stop_to_idle_state got %0d want 0", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd0) $display("FAIL stop_to_idle_sel got %0d want 0", rom_sel); else pass_cnt++;
  endtask

  task automatic test_box();
    knight_x  = 10'd100;
    knight_y  = 10'd200;
    face_left = 1'b0;
    tick();
    pixel(10'd149, 10'd263, 1'b1);
    total++; if (in_sprite !== 1'b1) $display("FAIL box_corner_hit got %0b want 1", in_sprite); else pass_cnt++;
    total++; if (rom_address !== 12'd3199) $display("FAIL box_corner_addr got %0d want 3199", rom_address); else pass_cnt++;
    pixel(10'd150, 10'd263, 1'b1);
    total++; if (in_sprite !== 1'b0) $display("FAIL box_right_edge_hit got %0b want 0", in_sprite); else pass_cnt++;
    total++; if (rom_address !== 12'd0) $display("FAIL box_right_edge_addr got %0d want 0", rom_address); else pass_cnt++;
    pixel(10'd99, 10'd210, 1'b1);
    total++; if (in_sprite !== 1'b0) $display("FAIL box_left_edge_hit got %0b want 0", in_sprite); else pass_cnt++;
    pixel(10'd110, 10'd201, 1'b1);
    total++; if (rom_address !== 12'd60) $display("FAIL box_inner_addr got %0d want 60", rom_address); else pass_cnt++;
    pixel(10'd120, 10'd264, 1'b1);
    total++; if (in_sprite !== 1'b0) $display("FAIL box_bottom_edge_hit got %0b want 0", in_sprite); else pass_cnt++;
    pixel(10'd149, 10'd263, 1'b0);
    total++; if (in_sprite !== 1'b0) $display("FAIL box_blank_hit got %0b want 0", in_sprite); else pass_cnt++;
    total++; if (rom_address !== 12'd0) $display("FAIL box_blank_addr got %0d want 0", rom_address); else pass_cnt++;
    // sprite hanging off the right edge: no wrap to the left of the screen
    knight_x = 10'd1000;
    tick();
    pixel(10'd5, 10'd200, 1'b1);
    total++; if (in_sprite !== 1'b0) $display("FAIL clip_nowrap_hit got %0b want 0", in_sprite); else pass_cnt++;
    pixel(10'd1023, 10'd200, 1'b1);
    total++; if (rom_address !== 12'd23) $display("FAIL clip_edge_addr got %0d want 23", rom_address); else pass_cnt++;
  endtask

  task automatic test_mirror();
    logic [11:0] exp_a;
    logic [11:0] exp_b;
`ifdef KNIGHT_MIRROR_EN
    exp_a = 12'd49;
    exp_b = 12'd3150;
`else
    exp_a = 12'd0;
    exp_b = 12'd3199;
`endif
    knight_x  = 10'd100;
    knight_y  = 10'd200;
    face_left = 1'b1;
    tick();
    pixel(10'd100, 10'd200, 1'b1);
    total++; if (rom_address !== exp_a) $display("FAIL mirror_first_col got %0d want %0d", rom_address, exp_a); else pass_cnt++;
    total++; if (in_sprite !== 1'b1) $display("FAIL mirror_hit got %0b want 1", in_sprite); else pass_cnt++;
    pixel(10'd149, 10'd263, 1'b1);
    total++; if (rom_address !== exp_b) $display("FAIL mirror_last_col got %0d want %0d", rom_address, exp_b); else pass_cnt++;
    face_left = 1'b0;
    tick();
  endtask

  task automatic test_midframe();
    knight_x = 10'd300;
    pixel(10'd149, 10'd263, 1'b1);
    total++; if (rom_address !== 12'd3199) $display("FAIL midframe_old_pos got %0d want 3199", rom_address); else pass_cnt++;
    tick();
    pixel(10'd149, 10'd263, 1'b1);
    total++; if (in_sprite !== 1'b0) $display("FAIL midframe_new_pos_miss got %0b want 0", in_sprite); else pass_cnt++;
    pixel(10'd349, 10'd263, 1'b1);
    total++; if (rom_address !== 12'd3199) $display("FAIL midframe_new_pos_addr got %0d want 3199", rom_address); else pass_cnt++;
  endtask

  task automatic test_reset_midwalk();
    walk_req = 1'b1;
    tick();
    tick();
    DrawX = 10'd310;
    DrawY = 10'd210;
    blank = 1'b1;
    step();
    total++; if (in_sprite !== 1'b1) $display("FAIL rstwalk_pre_hit got %0b want 1", in_sprite); else pass_cnt++;
    reset_n = 1'b0;
    step();
    total++; if (anim_state !== 2'd0) $display("FAIL rstwalk_state got %0d want 0", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd0) $display("FAIL rstwalk_sel got %0d want 0", rom_sel); else pass_cnt++;
    total++; if (in_sprite !== 1'b0) $display("FAIL rstwalk_hit got %0b want 0", in_sprite); else pass_cnt++;
    total++; if (rom_address !== 12'd0) $display("FAIL rstwalk_addr got %0d want 0", rom_address); else pass_cnt++;
    reset_n = 1'b1;
    // latched position cleared to 0: pixel (10,1) is inside the box at 50+10
    pixel(10'd10, 10'd1, 1'b1);
    total++; if (rom_address !== 12'd60) $display("FAIL rstwalk_latch_cleared got %0d want 60", rom_address); else pass_cnt++;
    step();
    total++; if (anim_state !== 2'd0) $display("FAIL rstwalk_idle_no_tick got %0d want 0", anim_state); else pass_cnt++;
    tick();
    total++; if (anim_state !== 2'd1) $display("FAIL rstwalk_restart_state got %0d want 1", anim_state); else pass_cnt++;
    total++; if (rom_sel !== 2'd1) $display("FAIL rstwalk_restart_sel got %0d want 1", rom_sel); else pass_cnt++;
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    walk_req   = 1'b0;
    face_left  = 1'b0;
    knight_x   = 10'd0;
    knight_y   = 10'd0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    blank      = 1'b0;
    #1;
    test_reset();
    test_idle();
    test_walk_cycle();
    test_stop();
    test_box();
    test_mirror();
    test_midframe();
    test_reset_midwalk();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
